mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store initiator for the 32-word × 64-bit data memory. It accepts one burst request at a time from the processor datapath and computes the word address as base + sign-extended offset. It then drives the memory's address/write-enable/data port. Load data is returned over a valid/ready stream, and store data is consumed from a valid/ready stream. The block sits between the execute stage and the data memory, and is the only agent driving the memory port.

## Interface
Parameters:
- ADDR_W, 5, memory word-address width (32 words)
- DATA_W, 64, data word width
- LEN_W, 3, burst-length field width; a burst moves req_len+1 words (1..8)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high together with req_valid
- req_store  in  1  1 = store burst, 0 = load burst
- req_base  in  DATA_W  base register value
- req_offset  in  16  signed word offset
- req_len  in  LEN_W  number of words minus one
- wr_valid  in  1  store word offered
- wr_ready  out  1  store word accepted
- wr_data  in  DATA_W  store word
- rd_valid  out  1  load word available
- rd_ready  in  1  consumer takes load word
- rd_data  out  DATA_W  load word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a burst completes
- mem_address  out  ADDR_W  memory word address
- mem_we  out  1  memory write enable; the write occurs at the next edge
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data (combinational from mem_address)

## Operation
- States: IDLE, LD_ISSUE, LD_HOLD, ST_XFER, DONE.
- IDLE: req_ready=1.
  - On req_valid, latch addr_q = (req_base + sext(req_offset))[ADDR_W-1:0], cnt_q = req_len, and op.
  - Go to ST_XFER if req_store, else LD_ISSUE.
  - Upper address bits are discarded silently.
- LD_ISSUE: mem_address=addr_q. At the edge, capture mem_dout into rd_data and set rd_valid; go to LD_HOLD.
- LD_HOLD: rd_valid=1, and rd_data is held stable until rd_ready.
  - On rd_ready, if cnt_q==0 go to DONE.
  - Otherwise addr_q += 1 (mod 2^ADDR_W, so 31 wraps to 0), cnt_q -= 1, go to LD_ISSUE.
- ST_XFER: wr_ready=1, mem_address=addr_q, mem_din=wr_data, mem_we = wr_valid.
  - Each accepted word writes mem[addr_q] at that edge.
  - If cnt_q==0, go to DONE; otherwise increment addr_q (wrapping) and decrement cnt_q, staying in ST_XFER.
- DONE: done=1 for exactly one cycle; go to IDLE.
- mem_we=1 only in ST_XFER with wr_valid. It is never asserted in any other state, and never during reset.
- req_ready is 0 outside IDLE, so a new request is never accepted while busy.
- wr_valid is ignored outside ST_XFER. rd_ready is ignored while rd_valid=0.
- Reset mid-burst: return to IDLE.
  - Words already written stay in memory, and the remaining words are abandoned.
  - rd_valid drops, and done is not pulsed.
- Reset values: state IDLE, addr_q 0, cnt_q 0, rd_data 0, rd_valid 0, done 0, busy 0, mem_we 0, mem_address 0, mem_din 0. req_ready=1 from the first cycle after reset. wr_ready=0.

## Timing
- Load, request handshake at cycle T:
  - LD_ISSUE at T+1.
  - rd_valid=1 with the word at T+2.
  - If rd_ready is high at T+2: DONE at T+3 for a single-word burst, else LD_ISSUE at T+3.
  - Peak rate is 1 word per 2 cycles.
- Store, request handshake at T: wr_ready=1 from T+1, and 1 word per cycle while wr_valid stays high.
- Last beat (last store accept or last rd handshake) at cycle L: done=1 at L+1, req_ready=1 at L+2.
- Back-to-back: a store to address A followed by a load from A returns the new value, because the write completes before LD_ISSUE samples.

## Structure
- Shared package mem_pkg: ADDR_W, DATA_W, LEN_W defaults and the state enum mem_state_t {IDLE, LD_ISSUE, LD_HOLD, ST_XFER, DONE}.
- One sub-module, mem_addr_gen: holds addr_q/cnt_q, with load (base+offset), step (increment/decrement with wrap), and a last flag (cnt_q==0).
- The FSM and stream handshakes stay in mem_access_ctrl.

## Test plan
Memory is preloaded with mem[0..5] = 0, 10, 20, 30, 40, -10.
- Single load: base=2, offset=1, len=0 -> rd_data=30 at T+2, done at T+3, mem_we never 1.
- Burst load with backpressure: base=1, offset=0, len=2, rd_ready low for 3 cycles on the second word -> stream 10, 20, 30; rd_data stable while stalled; exactly one done pulse.
- Negative offset and wrap: base=1, offset=-2, len=2 -> addresses 31, 0, 1; load returns mem[31], 0, 10.
- Store burst then readback: store base=4, len=1, data 0xAA then 0xBB, with wr_valid gapped one cycle -> mem[4]=0xAA and mem[5]=0xBB. A subsequent load of base=5 returns 0xBB.
- Request while busy: req_valid held during a load burst -> req_ready=0 until 2 cycles after the last beat, then accepted in IDLE.
- Reset mid-store: rst_n low after 1 of 3 words -> first word written, mem_we=0 during and after reset, IDLE, no done pulse, req_ready=1 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the data-memory access controller.
package mem_pkg;

    localparam int unsigned ADDR_W = 5;   // 32-word data memory
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LEN_W  = 3;   // burst of len+1 words
    localparam int unsigned OFF_W  = 16;  // signed word offset

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_HOLD,
        ST_XFER,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Burst address generator: loads base+offset and word count, then steps through the burst.
module mem_addr_gen #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::DATA_W,
    parameter int unsigned LEN_W  = mem_pkg::LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       step,
    input  logic [DATA_W-1:0]          base,
    input  logic [mem_pkg::OFF_W-1:0]  offset,
    input  logic [LEN_W-1:0]           len,
    output logic [ADDR_W-1:0]          addr,
    output logic                       last
);
    import mem_pkg::*;

    logic [ADDR_W-1:0]        addr_q;
    logic [LEN_W-1:0]         cnt_q;
    logic [DATA_W-1:0]        sum;
    logic [DATA_W-ADDR_W-1:0] unused_sum_hi;

    // Upper sum bits fall outside the memory and are dropped on purpose.
    assign sum           = base + {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign unused_sum_hi = sum[DATA_W-1:ADDR_W];

    // Address/count register: load on request accept, step after each non-final beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            addr_q <= sum[ADDR_W-1:0];
            cnt_q  <= len;
        end else if (step) begin
            addr_q <= addr_q + ADDR_W'(1);  // wraps 31 -> 0
            cnt_q  <= cnt_q - LEN_W'(1);
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store burst initiator: sole driver of the data-memory port, with valid/ready
// streams for load data out and store data in.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::DATA_W,
    parameter int unsigned LEN_W  = mem_pkg::LEN_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_store,
    input  logic [DATA_W-1:0]          req_base,
    input  logic [mem_pkg::OFF_W-1:0]  req_offset,
    input  logic [LEN_W-1:0]           req_len,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          mem_address,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_din,
    input  logic [DATA_W-1:0]          mem_dout
);
    import mem_pkg::*;

    mem_state_t        state_q, state_d;
    logic              ag_load, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic [DATA_W-1:0] rd_data_q;
    logic              st_xfer;

    mem_addr_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ag_load),
        .step   (ag_step),
        .base   (req_base),
        .offset (req_offset),
        .len    (req_len),
        .addr   (ag_addr),
        .last   (ag_last)
    );

    // State register; reset abandons any burst in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load data register: captures the memory word during LD_ISSUE, held through LD_HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (state_q == LD_ISSUE) begin
            rd_data_q <= mem_dout;
        end
    end

    // Next-state and address-generator controls.
    always_comb begin
        state_d = state_q;
        ag_load = 1'b0;
        ag_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ag_load = 1'b1;
                    state_d = req_store ? ST_XFER : LD_ISSUE;
                end
            end
            LD_ISSUE: state_d = LD_HOLD;
            LD_HOLD: begin
                if (rd_ready) begin
                    if (ag_last) begin
                        state_d = DONE;
                    end else begin
                        ag_step = 1'b1;
                        state_d = LD_ISSUE;
                    end
                end
            end
            ST_XFER: begin
                if (wr_valid) begin
                    if (ag_last) begin
                        state_d = DONE;
                    end else begin
                        ag_step = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port outputs; the write strobe is gated by reset so nothing is written while it is low.
    assign st_xfer     = (state_q == ST_XFER) && rst_n;
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign rd_valid    = (state_q == LD_HOLD);
    assign rd_data     = rd_data_q;
    assign wr_ready    = st_xfer;
    assign mem_we      = st_xfer && wr_valid;
    assign mem_din     = st_xfer ? wr_data : '0;
    assign mem_address = ag_addr;

endmodule
